// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Sequences the single-port data memory and shares it between the CPU MEM
//   stage (cpu port) and an external loader/debug port (ext port). Each
//   accepted request becomes a fixed-latency access of MEM_LAT cycles,
//   followed by one DONE cycle in which the result is presented to its owner.
//
// Ports
//   clk_i, rst_i                  clock (rising edge), asynchronous active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i CPU request, held stable while cpu_stall_o=1
//   cpu_rdata_o                   CPU read data, valid in the cycle cpu_stall_o falls
//   cpu_stall_o                   pipeline freeze (combinational)
//   ext_req_i/we_i/addr_i/wdata_i ext request, held until ext_gnt_o
//   ext_gnt_o                     1-cycle pulse: ext request has been latched
//   ext_rdata_o, ext_rvalid_o     ext completion pulse and read data
//   mem_en_o/we_o/addr_o/wdata_o  memory command (all registered)
//   mem_rdata_i                   memory read data, valid on MEM_LAT-th enable cycle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              ext_req_i,
    input  logic              ext_we_i,
    input  logic [ADDR_W-1:0] ext_addr_i,
    input  logic [DATA_W-1:0] ext_wdata_i,
    output logic              ext_gnt_o,
    output logic [DATA_W-1:0] ext_rdata_o,
    output logic              ext_rvalid_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_reg;
    logic [LAT_W-1:0]    lat_cnt_reg;
    logic [STARVE_W-1:0] starve_cnt_reg;
    logic                owner_ext_reg;
    logic                we_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                ext_gnt_reg;
    logic                ext_rvalid_reg;
    logic                mem_en_reg;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;

    // Arbitration: cpu has priority unless ext has been passed over
    // STARVE_MAX times in a row, in which case ext is forced through.
    logic              starve_full;
    logic              grant_ext;
    logic              grant_cpu;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign starve_full = (starve_cnt_reg == STARVE_LIMIT);
    assign grant_ext   = ext_req_i & (~cpu_req_i | starve_full);
    assign grant_cpu   = cpu_req_i & ~grant_ext;
    assign sel_we      = grant_ext ? ext_we_i    : cpu_we_i;
    assign sel_addr    = grant_ext ? ext_addr_i  : cpu_addr_i;
    assign sel_wdata   = grant_ext ? ext_wdata_i : cpu_wdata_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg      <= IDLE;
            lat_cnt_reg    <= '0;
            starve_cnt_reg <= '0;
            owner_ext_reg  <= 1'b0;
            we_reg         <= 1'b0;
            rdata_reg      <= '0;
            ext_gnt_reg    <= 1'b0;
            ext_rvalid_reg <= 1'b0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            // Pulse outputs default low every cycle.
            ext_gnt_reg    <= 1'b0;
            ext_rvalid_reg <= 1'b0;
            mem_we_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_cpu || grant_ext) begin
                        state_reg     <= ACCESS;
                        lat_cnt_reg   <= '0;
                        owner_ext_reg <= grant_ext;
                        we_reg        <= sel_we;
                        mem_addr_reg  <= sel_addr;
                        mem_wdata_reg <= sel_wdata;
                        mem_en_reg    <= 1'b1;
                        ext_gnt_reg   <= grant_ext;
                        // A single-cycle access strobes on its first cycle.
                        if (MEM_LAT == 1) begin
                            mem_we_reg <= sel_we;
                        end
                        if (grant_ext || !ext_req_i) begin
                            starve_cnt_reg <= '0;
                        end else if (!starve_full) begin
                            starve_cnt_reg <= starve_cnt_reg + STARVE_W'(1);
                        end
                    end
                end
                ACCESS: begin
                    if (lat_cnt_reg == LAT_LAST) begin
                        state_reg      <= DONE;
                        mem_en_reg     <= 1'b0;
                        ext_rvalid_reg <= owner_ext_reg;
                        if (!we_reg) begin
                            rdata_reg <= mem_rdata_i;
                        end
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
                        // Registered strobe: raise it for the final access cycle only.
                        if ((lat_cnt_reg + LAT_W'(1)) == LAT_LAST) begin
                            mem_we_reg <= we_reg;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Stall drops only in the DONE cycle of a cpu-owned access.
    assign cpu_stall_o  = cpu_req_i & ~((state_reg == DONE) & ~owner_ext_reg);
    assign cpu_rdata_o  = rdata_reg;
    assign ext_rdata_o  = rdata_reg;
    assign ext_gnt_o    = ext_gnt_reg;
    assign ext_rvalid_o = ext_rvalid_reg;
    assign mem_en_o     = mem_en_reg;
    assign mem_we_o     = mem_we_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_wdata_o  = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter: reset behaviour, a table of directed
//   single transactions, hand-written arbitration/starvation sequences and a
//   randomized phase checked against a transaction-level memory model.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              cpu_stall_o;
    logic              ext_req = 1'b0;
    logic              ext_we = 1'b0;
    logic [ADDR_W-1:0] ext_addr = '0;
    logic [DATA_W-1:0] ext_wdata = '0;
    logic              ext_gnt_o;
    logic [DATA_W-1:0] ext_rdata_o;
    logic              ext_rvalid_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .ext_req_i   (ext_req),
        .ext_we_i    (ext_we),
        .ext_addr_i  (ext_addr),
        .ext_wdata_i (ext_wdata),
        .ext_gnt_o   (ext_gnt_o),
        .ext_rdata_o (ext_rdata_o),
        .ext_rvalid_o(ext_rvalid_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'hDEADBEEF : (32'h5A000000 + 32'(i));
    endfunction

    // ---------------- memory model and activity monitors -------------------
    logic [31:0] mem [256];
    bit          preloaded = 1'b0;
    int          en_cnt = 0;
    int          cyc = 0;
    int          we_pulses = 0;
    int          en_cycles = 0;
    int          gnt_pulses = 0;
    int          rvalid_pulses = 0;
    int          stall_cycles = 0;
    int          viol = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    // Read data is only meaningful on the MEM_LAT-th enable cycle; elsewhere
    // a poison value exposes an early or late capture.
    assign mem_rdata = (mem_en_o && en_cnt == MEM_LAT) ? mem[mem_addr_o[9:2]] : 32'hBAD0BAD0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            preloaded <= 1'b1;
        end else if (mem_we_o) begin
            mem[mem_addr_o[9:2]] <= mem_wdata_o;
            we_pulses    <= we_pulses + 1;
            last_wr_addr <= mem_addr_o;
            last_wr_data <= mem_wdata_o;
        end
        en_cnt <= mem_en_o ? en_cnt + 1 : 0;
        if (mem_en_o)     en_cycles     <= en_cycles + 1;
        if (ext_gnt_o)    gnt_pulses    <= gnt_pulses + 1;
        if (ext_rvalid_o) rvalid_pulses <= rvalid_pulses + 1;
        if (cpu_stall_o)  stall_cycles  <= stall_cycles + 1;
        if ((ext_gnt_o && ext_rvalid_o) || (mem_we_o && !mem_en_o)) viol <= viol + 1;
    end

    // ---------------- helpers ----------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Call right after a falling edge. Returns at falling edge + 1 in DONE.
    task automatic cpu_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output int stall_n, output int done_cyc);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        stall_n = 0; done_cyc = -1; rd = '0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (!cpu_stall_o) begin
                rd = cpu_rdata_o;
                done_cyc = cyc;
                break;
            end
            stall_n++;
            @(negedge clk);
        end
        cpu_req = 1'b0;
        if (done_cyc < 0) check("cpu_timeout", 32'(0), 32'(1));
    endtask

    task automatic ext_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output int gnt_cyc);
        bit got;
        ext_we = we; ext_addr = addr; ext_wdata = wd; ext_req = 1'b1;
        gnt_cyc = -1; rd = '0; got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (ext_gnt_o) begin
                gnt_cyc = cyc;
                break;
            end
        end
        // Inputs may change after the grant; scramble them to prove latching.
        ext_req = 1'b0; ext_addr = 32'hFFFFFFFC; ext_wdata = ~wd; ext_we = ~we;
        if (gnt_cyc < 0) check("ext_gnt_timeout", 32'(0), 32'(1));
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (ext_rvalid_o) begin
                rd = ext_rdata_o;
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ext_rvalid_timeout", 32'(0), 32'(1));
    endtask

    // Transaction-level reference for the randomized phase: a word array plus
    // the single shared read-data register that only reads update.
    logic [31:0] ref_mem [8];
    logic [31:0] model_rd;

    function automatic logic [31:0] model_apply(input bit we, input int idx, input logic [31:0] wd);
        if (we) begin
            ref_mem[idx] = wd;
        end else begin
            model_rd = ref_mem[idx];
        end
        return model_rd;
    endfunction

    typedef struct {
        bit          is_ext;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [6];
        logic [31:0] rd_c, rd_e;
        int          sn, dc, gc;
        int          we0, en0, g0, r0, s0, n_done;
        bit          got;

        vecs[0] = '{1'b0, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b1, 32'h44, 32'h12345678, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b0, 32'h44, 32'h0,        32'h12345678};
        vecs[3] = '{1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 32'h80, 32'h0,        32'hCAFEF00D};
        vecs[5] = '{1'b0, 1'b0, 32'h80, 32'h0,        32'hCAFEF00D};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_en", 32'(mem_en_o), 32'(0));
        check("rst_mem_we", 32'(mem_we_o), 32'(0));
        check("rst_ext_gnt", 32'(ext_gnt_o), 32'(0));
        check("rst_ext_rvalid", 32'(ext_rvalid_o), 32'(0));
        check("rst_rdata", cpu_rdata_o, 32'h0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_wdata", mem_wdata_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("txn reset released");

        // ---- reset in the middle of a cpu write ----
        cpu_we = 1'b1; cpu_addr = 32'h48; cpu_wdata = 32'h55AA55AA; cpu_req = 1'b1;
        @(negedge clk); #1;
        check("midacc_mem_en", 32'(mem_en_o), 32'(1));
        check("midacc_mem_we", 32'(mem_we_o), 32'(0));
        we0 = we_pulses;
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_en", 32'(mem_en_o), 32'(0));
        check("async_rst_mem_we", 32'(mem_we_o), 32'(0));
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("rst_no_strobe", 32'(we_pulses - we0), 32'(0));
        check("rst_no_commit", mem[18], init_word(18));
        @(negedge clk);
        cpu_txn(1'b0, 32'h48, 32'h0, rd_c, sn, dc);
        check("post_rst_stall", 32'(sn), 32'(1 + MEM_LAT));
        check("post_rst_rdata", rd_c, init_word(18));
        $display("txn reset-mid-access stall=%0d rdata=%h", sn, rd_c);
        @(negedge clk);

        // ---- directed vector table ----
        for (int v = 0; v < 6; v++) begin
            we0 = we_pulses; en0 = en_cycles; g0 = gnt_pulses; r0 = rvalid_pulses; s0 = stall_cycles;
            if (vecs[v].is_ext) begin
                ext_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, rd_e, gc);
                check($sformatf("vec%0d_ext_rdata", v), rd_e, vecs[v].exp_rd);
            end else begin
                cpu_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, rd_c, sn, dc);
                check($sformatf("vec%0d_cpu_rdata", v), rd_c, vecs[v].exp_rd);
                check($sformatf("vec%0d_stall", v), 32'(sn), 32'(1 + MEM_LAT));
            end
            @(negedge clk); #1;
            check($sformatf("vec%0d_en_cycles", v), 32'(en_cycles - en0), 32'(MEM_LAT));
            check($sformatf("vec%0d_we_pulses", v), 32'(we_pulses - we0), 32'(vecs[v].we));
            if (vecs[v].we) begin
                check($sformatf("vec%0d_wr_addr", v), last_wr_addr, vecs[v].addr);
                check($sformatf("vec%0d_wr_data", v), last_wr_data, vecs[v].wdata);
            end
            if (vecs[v].is_ext) begin
                check($sformatf("vec%0d_gnt", v), 32'(gnt_pulses - g0), 32'(1));
                check($sformatf("vec%0d_rvalid", v), 32'(rvalid_pulses - r0), 32'(1));
                check($sformatf("vec%0d_cpu_quiet", v), 32'(stall_cycles - s0), 32'(0));
            end
            $display("txn vec%0d %s %s addr=%h", v, vecs[v].is_ext ? "ext" : "cpu",
                     vecs[v].we ? "wr" : "rd", vecs[v].addr);
        end

        // ---- simultaneous cpu and ext requests ----
        @(negedge clk);
        g0 = gnt_pulses; r0 = rvalid_pulses;
        fork
            cpu_txn(1'b0, 32'h44, 32'h0, rd_c, sn, dc);
            ext_txn(1'b0, 32'h80, 32'h0, rd_e, gc);
        join
        @(negedge clk); #1;
        check("both_cpu_rdata", rd_c, 32'h12345678);
        check("both_ext_rdata", rd_e, 32'hCAFEF00D);
        check("both_gnt_after_done", 32'(gc - dc), 32'(2));
        check("both_one_gnt", 32'(gnt_pulses - g0), 32'(1));
        check("both_one_rvalid", 32'(rvalid_pulses - r0), 32'(1));
        $display("txn simultaneous cpu_done=%0d ext_gnt=%0d", dc, gc);

        // ---- starvation: cpu held back-to-back with ext waiting ----
        @(negedge clk);
        g0 = gnt_pulses;
        cpu_we = 1'b0; cpu_addr = 32'h40; cpu_req = 1'b1;
        ext_we = 1'b0; ext_addr = 32'h80; ext_req = 1'b1;
        n_done = 0; got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (ext_gnt_o) begin
                got = 1'b1;
                break;
            end
            if (cpu_req && !cpu_stall_o) n_done++;
            @(negedge clk);
        end
        ext_req = 1'b0;
        check("starve_gnt_seen", 32'(got), 32'(1));
        check("starve_cpu_grants", 32'(n_done), 32'(STARVE_MAX));
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (ext_rvalid_o) begin
                rd_e = ext_rdata_o;
                got = 1'b1;
                break;
            end
        end
        check("starve_ext_rvalid", 32'(got), 32'(1));
        check("starve_ext_rdata", rd_e, 32'hCAFEF00D);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (!cpu_stall_o) begin
                rd_c = cpu_rdata_o;
                got = 1'b1;
                break;
            end
        end
        cpu_req = 1'b0;
        check("starve_cpu_resume", 32'(got), 32'(1));
        check("starve_cpu_rdata", rd_c, 32'hDEADBEEF);
        check("starve_one_gnt", 32'(gnt_pulses - g0), 32'(1));
        $display("txn starvation cpu_grants=%0d", n_done);

        // Counter must be back at zero: cpu wins a fresh tie again.
        @(negedge clk);
        @(negedge clk);
        fork
            cpu_txn(1'b0, 32'h44, 32'h0, rd_c, sn, dc);
            ext_txn(1'b0, 32'h80, 32'h0, rd_e, gc);
        join
        check("post_starve_cpu_first", 32'(gc - dc), 32'(2));
        check("post_starve_cpu_stall", 32'(sn), 32'(1 + MEM_LAT));
        $display("txn post-starvation tie cpu_done=%0d ext_gnt=%0d", dc, gc);
        @(negedge clk);

        // ---- randomized phase against the transaction-level model ----
        for (int i = 0; i < 8; i++) ref_mem[i] = init_word(64 + i);
        model_rd = 32'hCAFEF00D;
        for (int t = 0; t < 30; t++) begin
            int          mode, c_idx, e_idx;
            bit          c_we, e_we;
            logic [31:0] c_wd, e_wd, exp_c, exp_e;
            mode  = $urandom_range(0, 2);
            c_we  = 1'($urandom_range(0, 1));
            e_we  = 1'($urandom_range(0, 1));
            c_idx = $urandom_range(0, 7);
            e_idx = $urandom_range(0, 7);
            c_wd  = $urandom;
            e_wd  = $urandom;
            if (mode == 0) begin
                cpu_txn(c_we, 32'h100 + 32'(4 * c_idx), c_wd, rd_c, sn, dc);
                exp_c = model_apply(c_we, c_idx, c_wd);
                check($sformatf("rnd%0d_cpu_rdata", t), rd_c, exp_c);
                check($sformatf("rnd%0d_cpu_stall", t), 32'(sn), 32'(1 + MEM_LAT));
            end else if (mode == 1) begin
                ext_txn(e_we, 32'h100 + 32'(4 * e_idx), e_wd, rd_e, gc);
                exp_e = model_apply(e_we, e_idx, e_wd);
                check($sformatf("rnd%0d_ext_rdata", t), rd_e, exp_e);
            end else begin
                fork
                    cpu_txn(c_we, 32'h100 + 32'(4 * c_idx), c_wd, rd_c, sn, dc);
                    ext_txn(e_we, 32'h100 + 32'(4 * e_idx), e_wd, rd_e, gc);
                join
                exp_c = model_apply(c_we, c_idx, c_wd);
                exp_e = model_apply(e_we, e_idx, e_wd);
                check($sformatf("rnd%0d_both_cpu_rdata", t), rd_c, exp_c);
                check($sformatf("rnd%0d_both_ext_rdata", t), rd_e, exp_e);
                check($sformatf("rnd%0d_both_order", t), 32'(gc - dc), 32'(2));
            end
            $display("txn rnd%0d mode=%0d cpu_%s[%0d] ext_%s[%0d]", t, mode,
                     c_we ? "wr" : "rd", c_idx, e_we ? "wr" : "rd", e_idx);
            @(negedge clk);
        end
        @(negedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("final_mem%0d", i), mem[64 + i], ref_mem[i]);
        end
        check("protocol_violations", 32'(viol), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
